// File: rtl/fnd_pkg.sv
// Shared types, segment constants and the double-dabble step for the FND outport display.
package fnd_pkg;

    localparam int unsigned BIN_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned SR_W  = BCD_W + BIN_W;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_of(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One shift-add-3 step over {hundreds, tens, ones, binary}.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < 3; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep, last-value-wins pending slot.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  data_in,
    input  logic              data_valid,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd
);

    state_t             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [2:0]         iter_q;
    logic [BIN_W-1:0]   pend_q;
    logic               pend_vld_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            iter_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        sr_q    <= {{BCD_W{1'b0}}, data_in};
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    sr_q   <= dd_step(sr_q);
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        state_q <= DONE;
                    end
                    if (data_valid) begin
                        pend_q     <= data_in;
                        pend_vld_q <= 1'b1;
                    end
                end
                DONE: begin
                    bcd_q <= sr_q[SR_W-1:BIN_W];
                    // A strobe arriving in DONE is newer than anything pending.
                    if (data_valid || pend_vld_q) begin
                        sr_q       <= {{BCD_W{1'b0}}, (data_valid ? data_in : pend_q)};
                        iter_q     <= '0;
                        pend_vld_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/fnd_outport_display.sv
// Outport capture, BCD conversion and 4-digit multiplexed FND drive.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_outport_display
    import fnd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_font
);

`ifdef FND_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       com_q;
    logic [7:0]       font_q;
    logic [3:0]       nib;
    logic             blank;
    logic             hund_zero;
    logic             tens_zero;

    bin2bcd_seq u_bin2bcd_seq (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .busy       (busy),
        .bcd        (bcd_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q <= '0;
            idx_q         <= '0;
        end else if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_q <= '0;
            idx_q         <= idx_q + 2'd1;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
        end
    end

    assign hund_zero = (bcd_out[11:8] == 4'd0);
    assign tens_zero = (bcd_out[7:4] == 4'd0);

    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        case (idx_q)
            2'd0: nib = bcd_out[3:0];
            2'd1: begin
                nib   = bcd_out[7:4];
                blank = LZB && hund_zero && tens_zero;
            end
            2'd2: begin
                nib   = bcd_out[11:8];
                blank = LZB && hund_zero;
            end
            default: begin
                nib   = 4'd0;
                blank = LZB;
            end
        endcase
    end

    // Digit enable and font are registered together so segments never straddle a digit change.
    always_ff @(posedge clk) begin
        if (reset) begin
            com_q  <= 4'b1110;
            font_q <= SEG_0;
        end else begin
            com_q  <= ~(4'b0001 << idx_q);
            font_q <= blank ? SEG_BLANK : seg_of(nib);
        end
    end

    assign fnd_com  = com_q;
    assign fnd_font = font_q;

endmodule

// File: tb/tb_fnd_outport_display.sv
// Scoreboard bench: a cycle-level behavioural model queues expected outputs per edge.
module tb_fnd_outport_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = 8'd0;
    logic        data_valid = 1'b0;
    logic        busy;
    logic [11:0] bcd_out;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_font;

    fnd_outport_display #(
        .REFRESH_DIV (DIV),
        .CNT_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .busy       (busy),
        .bcd_out    (bcd_out),
        .fnd_com    (fnd_com),
        .fnd_font   (fnd_font)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic       busy;
        logic [11:0] bcd;
        logic [3:0] com;
        logic [7:0] font;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Model state: displayed value, conversion in flight, pending slot.
    int m_val = 0, m_cur = 0, m_end = 0, m_rbase = 0, m_pend = 0;
    bit m_active = 0, m_pend_v = 0;

    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [7:0] font_of(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return (d < 0) ? 8'hFF : tbl[d];
    endfunction

    // Digit shown in slot idx for value v; -1 means blank.
    function automatic int digit_of(input int v, input int idx);
        int h, t, o;
        bit lzb;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
`ifdef FND_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        case (idx)
            0: return o;
            1: return (lzb && h == 0 && t == 0) ? -1 : t;
            2: return (lzb && h == 0) ? -1 : h;
            default: return lzb ? -1 : 0;
        endcase
    endfunction

    function automatic void start_conv(input int v, input int e);
        m_active = 1;
        m_cur    = v;
        m_end    = e + 9;
        m_pend_v = 0;
    endfunction

    // Predict the state of all outputs after edge e.
    function automatic void model_edge(input int e, input bit rst, input bit dv, input int d);
        exp_t x;
        int   prev_val, k, idx;
        prev_val  = m_val;
        x.edge_no = e;
        if (rst) begin
            m_active = 0;
            m_pend_v = 0;
            m_val    = 0;
            m_rbase  = e;
            x.com    = 4'b1110;
            x.font   = 8'hC0;
        end else begin
            if (m_active && e == m_end) begin
                m_val = m_cur;
                if (dv) start_conv(d, e);
                else if (m_pend_v) start_conv(m_pend, e);
                else m_active = 0;
            end else if (m_active) begin
                if (dv) begin
                    m_pend_v = 1;
                    m_pend   = d;
                end
            end else if (dv) begin
                start_conv(d, e);
            end
            k      = e - m_rbase;
            idx    = ((k - 1) / DIV) % 4;
            x.com  = ~(4'b0001 << idx);
            x.font = font_of(digit_of(prev_val, idx));
        end
        x.busy = m_active;
        x.bcd  = bcd_of(m_val);
        q.push_back(x);
    endfunction

    task automatic step(input bit rst, input bit dv, input int d);
        @(negedge clk);
        reset      = rst;
        data_valid = dv;
        data_in    = 8'(d);
        model_edge(cyc + 1, rst, dv, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic chk(input string name, input int e, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, e, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t x;
        cyc++;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("busy", x.edge_no, 12'(busy), 12'(x.busy));
            chk("bcd_out", x.edge_no, bcd_out, x.bcd);
            chk("fnd_com", x.edge_no, 12'(fnd_com), 12'(x.com));
            chk("fnd_font", x.edge_no, 12'(fnd_font), 12'(x.font));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        idle(20);
        step(0, 1, 55);  idle(30);
        step(0, 1, 255); idle(12);
        step(0, 1, 0);   idle(20);
        // Burst: 100 is overwritten by 200 while the first conversion runs.
        step(0, 1, 12);  idle(2); step(0, 1, 100); idle(2); step(0, 1, 200); idle(30);
        // Reset lands in the fourth CONV cycle.
        step(0, 1, 99);  idle(3); step(1, 0, 0); idle(20);
        step(0, 1, 123); idle(40);
        // Strobe arriving exactly in DONE.
        step(0, 1, 50);  idle(8); step(0, 1, 7); idle(20);
        for (int i = 0; i < 2500; i++) begin
            bit rst, dv;
            rst = ($urandom_range(0, 299) == 0);
            dv  = ($urandom_range(0, 5) == 0);
            step(rst, dv, int'($urandom_range(0, 255)));
        end
        idle(20);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fnd_outport_display.md
Name: fnd_outport_display

Overview:
- Consumer end of the dedicated processor's 8-bit outport.
- Captures the value when the processor's output-load strobe fires and converts binary to BCD with a sequential double-dabble engine.
- Drives a 4-digit common-anode 7-segment (FND) display by time-multiplexed digit scanning.
- Sits at the top level between the processor core and the board FND pins.

Parameters:
- REFRESH_DIV, 100_000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2.
- CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  unsigned value from the processor outport.
- data_valid  input  1  one-cycle strobe; data_in is sampled in the same cycle.
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  12  currently displayed value as {hundreds, tens, ones} BCD.
- fnd_com  output  4  digit enables, active-low, one-hot; bit 0 = ones digit.
- fnd_font  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset values: busy=0, bcd_out=12'h000, fnd_com=4'b1110, fnd_font=8'hC0, refresh counter=0, digit index=0, pending flag clear, FSM=IDLE.
- Reset mid-conversion aborts the conversion, discards any pending value and restores all reset values.
- FSM states:
  - IDLE: on data_valid, load the shift register {12'h000, data_in}, set iteration count to 0, go to CONV.
  - CONV: one double-dabble step per cycle. For each BCD nibble, add 3 if the nibble is >= 5, then shift left by 1. After the 8th step go to DONE.
  - DONE: latch the BCD result into bcd_out. If the pending flag is set, reload from the pending register, clear the flag and go to CONV. Otherwise go to IDLE.
- busy=1 in CONV and DONE.
- Latency: data_valid at rising edge N produces an updated bcd_out visible after edge N+9.
- data_valid while busy: value stored in a one-deep pending register. A later strobe overwrites it (last value wins). No strobe is ever dropped silently except by being overwritten.
- data_valid in DONE with the pending flag clear: treated as pending and converted immediately after DONE.
- Value range 0..255; the hundreds nibble is never > 2. The thousands digit is always blank/zero.
- Scanning: the refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - fnd_com = ~(4'b0001 << index).
  - Digit 3 shows '0' (C0).
- fnd_com and fnd_font are registered and change together, one cycle after the index update.
- Font table: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 blank:FF. dp is always off.
- The display reads bcd_out only, so no partially-converted value is ever shown.

Optional Feature:
- Macro: FND_LZB_EN (leading-zero blanking).
- Defined:
  - Digit 3 always blank (FF).
  - Digit 2 blank if hundreds=0.
  - Digit 1 blank if hundreds=0 and tens=0.
  - Digit 0 is never blanked, so value 0 shows a single '0'.
- Undefined: all four digits are displayed, including zeros.
- bcd_out and busy are identical in both builds.

Decomposition:
- Package fnd_pkg:
  - FSM state enum {IDLE, CONV, DONE}.
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - BIN_W=8, BCD_W=12.
- Sub-module bin2bcd_seq: the IDLE/CONV/DONE engine with pending register, outputting bcd and busy.
- The top level holds the scan counter, digit mux and font decode.

Test Plan:
- Reset, then idle 20 cycles → bcd_out=000, busy=0, fnd_com=1110, fnd_font=C0.
- data_valid with data_in=55 (processor sum 0..10) → busy high 9 cycles, bcd_out=055 after edge N+9.
  - With REFRESH_DIV=4, fnd_font cycles 92,92,C0,C0.
  - With FND_LZB_EN: 92,92,FF,FF.
- data_in=255 → bcd_out=255. data_in=0 → bcd_out=000. With LZB, font sequence is C0,FF,FF,FF.
- Strobe 12, then strobes 100 and 200 while busy → bcd_out goes 012, then 200. 100 is never displayed; total busy=18 cycles.
- Strobe 99, assert reset at cycle 4 of CONV → bcd_out=000, busy=0, and no conversion resumes after reset deasserts.
- REFRESH_DIV=4, static value 123 → fnd_com sequence 1110,1101,1011,0111 repeating every 16 cycles. Fonts are F9 (3 → B0 on ones), i.e. ones=B0, tens=A4, hundreds=F9, thousands=C0.
